uparc_alu_pipe: RTL and testbench

UPARC_ALU_PIPE -- requirements
Module: uparc_alu_pipe

---
 rtl/uparc_alu_pipe.sv | 163 ++++++++++++++++
 tb/tb_uparc_alu_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uparc_alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Optional CLZ/CLO counting logic is enabled by defining UPARC_ALU_CLZ_EN.
module uparc_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAGW-1:0]  i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovflow,
  output logic [TAGW-1:0]  o_tag
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOR  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_CLZ  = 4'd11,
    OP_CLO  = 4'd12
  } alu_op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [TAGW-1:0]  s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_ovflow_q;
  logic [TAGW-1:0]  s2_tag_q;

  logic             s2_free;
  logic             accept;
  logic             s1_move;

  // S2 can take new data when empty or when its current result leaves this cycle.
  assign s2_free = !s2_valid_q || o_ready;
  assign i_ready = (!s1_valid_q || s2_free) && !flush;
  assign accept  = i_valid && i_ready;
  assign s1_move = s1_valid_q && s2_free;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)       s1_valid_d = 1'b1;
      else if (s1_move) s1_valid_d = 1'b0;
      if (s2_free)      s2_valid_d = s1_valid_q;
    end
  end

  logic [WIDTH-1:0] b_eff, sum, alu_res;
  logic [SHW-1:0]   shamt;
  logic             is_sub, add_ovf, alu_ovf;

  assign is_sub  = (s1_op_q == OP_SUB);
  assign b_eff   = is_sub ? ~s1_b_q : s1_b_q;
  assign sum     = s1_a_q + b_eff + WIDTH'(is_sub);
  assign add_ovf = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
  assign shamt   = s1_b_q[SHW-1:0];

`ifdef UPARC_ALU_CLZ_EN
  logic [WIDTH-1:0] scan;
  logic [SHW:0]     lead_cnt;
  logic             lead_done;

  // CLO counts leading zeros of the inverted operand.
  assign scan = (s1_op_q == OP_CLO) ? ~s1_a_q : s1_a_q;

  always_comb begin
    lead_cnt  = '0;
    lead_done = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!lead_done) begin
        if (scan[WIDTH-1-i]) lead_done = 1'b1;
        else                 lead_cnt  = lead_cnt + (SHW+1)'(1);
      end
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SLL:  alu_res = s1_a_q << shamt;
      OP_SRL:  alu_res = s1_a_q >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(s1_a_q) >>> shamt);
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
      OP_NOR:  alu_res = ~(s1_a_q | s1_b_q);
      OP_SLT:  alu_res = WIDTH'($signed(s1_a_q) < $signed(s1_b_q));
      OP_SLTU: alu_res = WIDTH'(s1_a_q < s1_b_q);
`ifdef UPARC_ALU_CLZ_EN
      OP_CLZ, OP_CLO: alu_res = WIDTH'(lead_cnt);
`endif
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovflow_q <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_op_q  <= i_op;
        s1_a_q   <= i_a;
        s1_b_q   <= i_b;
        s1_tag_q <= i_tag;
      end
      if (s1_move && !flush) begin
        s2_result_q <= alu_res;
        s2_ovflow_q <= alu_ovf;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

  assign o_valid  = s2_valid_q;
  assign o_result = s2_result_q;
  assign o_ovflow = s2_ovflow_q;
  assign o_tag    = s2_tag_q;

endmodule

// File: tb/tb_uparc_alu_pipe.sv
// Directed self-checking bench for uparc_alu_pipe (WIDTH=32); CLZ/CLO
// expectations follow whether UPARC_ALU_CLZ_EN is defined.
module tb_uparc_alu_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int TAGW  = 5;

  logic             clk = 1'b0;
  logic             nrst;
  logic             flush;
  logic             i_valid;
  logic             i_ready;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] i_a, i_b;
  logic [TAGW-1:0]  i_tag;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_ovflow;
  logic [TAGW-1:0]  o_tag;

  int n_cmp = 0;
  int n_bad = 0;

  uparc_alu_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .flush    (flush),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
    .o_ovflow (o_ovflow),
    .o_tag    (o_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    i_valid = v;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_tag   = tag;
  endtask

  // Single operation with o_ready high: nothing after one cycle, result after two.
  task automatic issue_one(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           input logic [31:0] exp_res, input logic exp_ov);
    o_ready = 1'b1;
    drive(1'b1, op, a, b, tag);
    @(negedge clk);
    drive(1'b0, 4'd0, '0, '0, '0);
    check({name, "_lat1_valid"}, 64'(o_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(o_valid), 64'd1);
    check({name, "_res"}, 64'(o_result), 64'(exp_res));
    check({name, "_ov"}, 64'(o_ovflow), 64'(exp_ov));
    check({name, "_tag"}, 64'(o_tag), 64'(tag));
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; o_ready = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0);
    #12;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_res", 64'(o_result), 64'd0);
    check("rst_ov", 64'(o_ovflow), 64'd0);
    check("rst_tag", 64'(o_tag), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("rst_iready", 64'(i_ready), 64'd1);
    @(negedge clk);

    issue_one("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h1,         5'd1,  32'h8000_0000, 1'b1);
    issue_one("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,         5'd2,  32'h0000_0000, 1'b0);
    issue_one("sub_neg",  4'd1,  32'd5,         32'd7,         5'd3,  32'hFFFF_FFFE, 1'b0);
    issue_one("sll",      4'd2,  32'h1,         32'h24,        5'd4,  32'h0000_0010, 1'b0);
    issue_one("srl",      4'd3,  32'h8000_0000, 32'd31,        5'd5,  32'h0000_0001, 1'b0);
    issue_one("and",      4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6,  32'hF000_F000, 1'b0);
    issue_one("or",       4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'hFFF0_FFF0, 1'b0);
    issue_one("xor",      4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8,  32'h0FF0_0FF0, 1'b0);
    issue_one("nor",      4'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  32'h000F_000F, 1'b0);
    issue_one("slt",      4'd9,  32'hFFFF_FFFF, 32'h1,         5'd10, 32'h1,         1'b0);
    issue_one("sltu",     4'd10, 32'hFFFF_FFFF, 32'h1,         5'd11, 32'h0,         1'b0);
    issue_one("undef13",  4'd13, 32'h7FFF_FFFF, 32'h1,         5'd12, 32'h0,         1'b0);
`ifdef UPARC_ALU_CLZ_EN
    issue_one("clz_bit16", 4'd11, 32'h0001_0000, 32'hFFFF_FFFF, 5'd13, 32'd15, 1'b0);
    issue_one("clo_all",   4'd12, 32'hFFFF_FFFF, 32'h0,         5'd14, 32'd32, 1'b0);
    issue_one("clz_zero",  4'd11, 32'h0,         32'h0,         5'd15, 32'd32, 1'b0);
`else
    issue_one("clz_off",   4'd11, 32'h0001_0000, 32'h0,         5'd13, 32'd0,  1'b0);
    issue_one("clo_off",   4'd12, 32'hFFFF_FFFF, 32'h0,         5'd14, 32'd0,  1'b0);
`endif

    // Back-to-back SUB then SRA: results on consecutive cycles, in order.
    o_ready = 1'b1;
    drive(1'b1, 4'd1, 32'h8000_0000, 32'h1, 5'd20);
    @(negedge clk);
    drive(1'b1, 4'd4, 32'h8000_0000, 32'h23, 5'd21);
    @(negedge clk);
    drive(1'b0, 4'd0, '0, '0, '0);
    check("b2b_sub_valid", 64'(o_valid), 64'd1);
    check("b2b_sub_res", 64'(o_result), 64'h7FFF_FFFF);
    check("b2b_sub_ov", 64'(o_ovflow), 64'd1);
    check("b2b_sub_tag", 64'(o_tag), 64'd20);
    @(negedge clk);
    check("b2b_sra_valid", 64'(o_valid), 64'd1);
    check("b2b_sra_res", 64'(o_result), 64'hF000_0000);
    check("b2b_sra_ov", 64'(o_ovflow), 64'd0);
    check("b2b_sra_tag", 64'(o_tag), 64'd21);
    @(negedge clk);
    check("b2b_drain", 64'(o_valid), 64'd0);

    // Backpressure: two accepted, third stalls, output held stable.
    o_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd10, 32'd1, 5'd1);
    @(negedge clk);
    #1 check("bp_ready1", 64'(i_ready), 64'd1);
    drive(1'b1, 4'd0, 32'd20, 32'd2, 5'd2);
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd30, 32'd3, 5'd3);
    #1 check("bp_stall", 64'(i_ready), 64'd0);
    @(negedge clk);
    check("bp_hold_valid", 64'(o_valid), 64'd1);
    check("bp_hold_tag", 64'(o_tag), 64'd1);
    check("bp_hold_res", 64'(o_result), 64'd11);
    check("bp_stall2", 64'(i_ready), 64'd0);
    @(negedge clk);
    check("bp_stable_tag", 64'(o_tag), 64'd1);
    check("bp_stable_res", 64'(o_result), 64'd11);
    o_ready = 1'b1;
    #1 check("bp_ready_resume", 64'(i_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 4'd0, '0, '0, '0);
    check("bp_tag2", 64'(o_tag), 64'd2);
    check("bp_res2", 64'(o_result), 64'd22);
    @(negedge clk);
    check("bp_tag3_valid", 64'(o_valid), 64'd1);
    check("bp_tag3", 64'(o_tag), 64'd3);
    check("bp_res3", 64'(o_result), 64'd33);
    @(negedge clk);
    check("bp_drain", 64'(o_valid), 64'd0);

    // Flush with two in flight and a simultaneous request.
    o_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd5);
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd2, 32'd2, 5'd6);
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd3, 32'd3, 5'd7);
    flush = 1'b1;
    #1 check("flush_iready", 64'(i_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0);
    check("flush_valid", 64'(o_valid), 64'd0);
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_no_emit", 64'(o_valid), 64'd0);
    end

    // Asynchronous reset with two operations in flight.
    o_ready = 1'b0;
    drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd9);
    @(negedge clk);
    drive(1'b1, 4'd0, 32'd4, 32'd4, 5'd10);
    @(negedge clk);
    drive(1'b0, 4'd0, '0, '0, '0);
    check("pre_rst_valid", 64'(o_valid), 64'd1);
    #2 nrst = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_res", 64'(o_result), 64'd0);
    check("arst_ov", 64'(o_ovflow), 64'd0);
    check("arst_tag", 64'(o_tag), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    o_ready = 1'b1;
    @(negedge clk);
    check("post_rst_empty", 64'(o_valid), 64'd0);
    issue_one("post_rst", 4'd0, 32'd100, 32'd23, 5'd17, 32'd123, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
